// File: rtl/ospfb_run_ctrl.sv
// Run sequencer for the OSPFB: one FFT config beat, then enables the OSPFB for a programmed frame count.
// Optional macro OSPFB_RUN_CTRL_OVF_HALT_EN makes FFT overflow in CONFIG/RUN fatal.
module ospfb_run_ctrl #(
  parameter int CONF_WID = 8,
  parameter int FRM_WID  = 16,
  parameter int OVF_WID  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [CONF_WID-1:0] cfg_word,
  input  logic [FRM_WID-1:0]  num_frames,
  output logic [CONF_WID-1:0] m_axis_config_tdata,
  output logic                m_axis_config_tvalid,
  input  logic                m_axis_config_tready,
  input  logic                data_tvalid,
  input  logic                data_tready,
  input  logic                data_tlast,
  input  logic                event_frame_started,
  input  logic                event_tlast_unexpected,
  input  logic                event_tlast_missing,
  input  logic                event_fft_overflow,
  input  logic                event_data_in_channel_halt,
  output logic                ospfb_en,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [3:0]          err_flags,
  output logic [FRM_WID-1:0]  frm_cnt,
  output logic [OVF_WID-1:0]  ovf_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONFIG = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CONF_WID-1:0] cfg_q, cfg_d;
  logic [FRM_WID-1:0]  nfrm_q, nfrm_d;
  logic [FRM_WID-1:0]  frm_cnt_q, frm_cnt_d;
  logic [OVF_WID-1:0]  ovf_cnt_q, ovf_cnt_d;
  logic [3:0]          err_flags_q, err_flags_d;
  logic                ospfb_en_q, ospfb_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                tvalid_q, tvalid_d;

  logic       frame_beat;
  logic       ovf_ev;
  logic       ovf_fatal;
  logic [3:1] fatal_bits;

  // event_frame_started carries no control meaning here
  logic unused_ok;
  assign unused_ok = event_frame_started;

  assign frame_beat = data_tvalid & data_tready & data_tlast;
  assign ovf_ev     = event_fft_overflow & (state_q != ST_IDLE);
  assign fatal_bits = {event_data_in_channel_halt, event_tlast_missing, event_tlast_unexpected};

`ifdef OSPFB_RUN_CTRL_OVF_HALT_EN
  assign ovf_fatal = event_fft_overflow;
`else
  assign ovf_fatal = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    nfrm_d      = nfrm_q;
    frm_cnt_d   = frm_cnt_q;
    ovf_cnt_d   = ovf_cnt_q;
    err_flags_d = err_flags_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d       = cfg_word;
          nfrm_d      = num_frames;
          frm_cnt_d   = '0;
          ovf_cnt_d   = '0;
          err_flags_d = '0;
          state_d     = ST_CONFIG;
        end
      end
      ST_CONFIG, ST_RUN: begin
        // abort wins over any frame completion or event in the same cycle
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          if (state_q == ST_RUN && frame_beat) begin
            frm_cnt_d = frm_cnt_q + 1'b1;
          end
          err_flags_d[3:1] = err_flags_q[3:1] | fatal_bits;
          if ((|fatal_bits) || ovf_fatal) begin
            state_d = ST_ERROR;
          end else if (state_q == ST_CONFIG && m_axis_config_tready) begin
            state_d = ST_RUN;
          end else if (state_q == ST_RUN && frame_beat &&
                       nfrm_q != '0 && frm_cnt_d == nfrm_q) begin
            state_d = ST_DRAIN;
            done_d  = 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      ST_ERROR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ovf_ev) begin
      if (ovf_cnt_q != '1) begin
        ovf_cnt_d = ovf_cnt_q + 1'b1;
      end
      err_flags_d[0] = 1'b1;
    end

    // outputs are decoded from the next state so they leave the flops aligned with it
    ospfb_en_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE);
    err_d      = (state_d == ST_ERROR);
    tvalid_d   = (state_d == ST_CONFIG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      nfrm_q      <= '0;
      frm_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
      err_flags_q <= '0;
      ospfb_en_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      nfrm_q      <= nfrm_d;
      frm_cnt_q   <= frm_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      err_flags_q <= err_flags_d;
      ospfb_en_q  <= ospfb_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tvalid_q    <= tvalid_d;
    end
  end

  assign m_axis_config_tdata  = cfg_q;
  assign m_axis_config_tvalid = tvalid_q;
  assign ospfb_en             = ospfb_en_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign err                  = err_q;
  assign err_flags            = err_flags_q;
  assign frm_cnt              = frm_cnt_q;
  assign ovf_cnt              = ovf_cnt_q;

endmodule

// File: doc/ospfb_run_ctrl.md
# ospfb_run_ctrl

Run sequencer for the oversampled PFB datapath. On `start` it pushes one configuration word into the FFT config channel, enables the OSPFB, counts output frames on the data stream and stops after a programmed number of frames. It also latches the OSPFB/FFT event flags into sticky error status and terminates the run on fatal events. It sits between the test or host control logic and the `OSPFB` instance, and drives that instance's `en`.

## Interface
- `CONF_WID`, 8: FFT config word width (fwd/inv bit plus scale schedule).
- `FRM_WID`, 16: width of the frame-count target and frame counter.
- `OVF_WID`, 16: width of the saturating FFT-overflow counter.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle run request; sampled only in IDLE.
- `abort` in 1: stop the run and return to IDLE.
- `cfg_word` in CONF_WID: FFT config word; latched when `start` is accepted.
- `num_frames` in FRM_WID: frames per run, latched on `start`; 0 = free-run.
- `m_axis_config` axis.MST (WIDTH=CONF_WID): FFT config channel (`tdata`, `tvalid`, `tready`).
- `data_tvalid`, `data_tready`, `data_tlast` in 1 each: monitor taps on the OSPFB output stream.
- `event_frame_started`, `event_tlast_unexpected`, `event_tlast_missing`, `event_fft_overflow`, `event_data_in_channel_halt` in 1 each: FFT event strobes.
- `ospfb_en` out 1: drives the OSPFB `en` input.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `err` out 1: high while in ERROR.
- `err_flags` out 4: sticky, bits {halt, tlast_missing, tlast_unexpected, fft_overflow}.
- `frm_cnt` out FRM_WID: frames completed in the current run.
- `ovf_cnt` out OVF_WID: saturating count of `event_fft_overflow` pulses.

## Operation
- States: IDLE, CONFIG, RUN, DRAIN, ERROR.
- IDLE:
  - `start` → latch `cfg_word` and `num_frames`, clear `frm_cnt`, `ovf_cnt` and `err_flags`, go to CONFIG.
  - `abort` in IDLE has no effect.
- CONFIG:
  - `m_axis_config.tvalid`=1 and `tdata`=latched word; both are held stable until `tready`.
  - On handshake (`tvalid & tready`), go to RUN.
  - `ospfb_en`=0 throughout CONFIG.
- RUN:
  - `ospfb_en`=1.
  - A frame is one beat with `data_tvalid & data_tready & data_tlast`; each frame increments `frm_cnt`.
  - When `num_frames`≠0 and the increment makes `frm_cnt` equal `num_frames`, go to DRAIN.
  - With `num_frames`=0, `frm_cnt` wraps modulo 2^FRM_WID and the run ends only on `abort` or an error.
- DRAIN: `ospfb_en`=0 for exactly one cycle, `done`=1 in that cycle, then IDLE.
- Fatal events: `event_tlast_unexpected`, `event_tlast_missing` or `event_data_in_channel_halt` in CONFIG or RUN → set the matching `err_flags` bit, go to ERROR, drop `ospfb_en` on the next edge.
- ERROR:
  - `err`=1, `ospfb_en`=0.
  - Stays in ERROR until `abort`, which returns to IDLE. `err_flags` are retained and cleared only by the next accepted `start` or by `rst`.
  - `start` is ignored in ERROR.
- `event_fft_overflow`: increments `ovf_cnt` in any state except IDLE, saturating at all-ones, and sets `err_flags[0]`. Whether it is fatal depends on Configuration.
- `abort` in CONFIG or RUN: back to IDLE next cycle, `tvalid` and `ospfb_en` drop, no `done`. `abort` takes priority over a simultaneous frame completion or event.
- Simultaneous fatal event and final frame: `frm_cnt` still increments, the error wins (go to ERROR), no `done`.
- `event_frame_started` has no effect on state; it is used only by the bench for checks.

## Timing
- Reset values: state IDLE; `ospfb_en`, `busy`, `done`, `err`, `m_axis_config.tvalid`=0; `m_axis_config.tdata`, `err_flags`, `frm_cnt`, `ovf_cnt`=0.
- All outputs are registered. Decisions take effect on the edge after the qualifying input.
- `start` accepted at edge N: `busy` and `tvalid` are high from cycle N+1.
- Config handshake at edge M: `ospfb_en`=1 from cycle M+1.
- Last frame beat at edge K: `frm_cnt` updated and `ospfb_en`=0 at K+1, `done` at K+1, IDLE at K+2.
- A `rst` asserted mid-run returns every output to its reset value on the next edge, including a mid-handshake `tvalid`. No config beat is completed by the reset.

## Configuration
- `OSPFB_RUN_CTRL_OVF_HALT_EN` defined: `event_fft_overflow` in CONFIG or RUN is fatal. It sets `err_flags[0]` and goes to ERROR, and `ovf_cnt` still increments.
- Not defined: overflow is counted and flagged only, and the run continues.

## Test plan
- Normal run: `cfg_word`=0x5A, `num_frames`=3, `tready` delayed 4 cycles → single config beat 0x5A held stable; `ospfb_en` high for the run; `done` pulses the cycle after the 3rd tlast; `frm_cnt`=3.
- Free-run: `num_frames`=0, 10 frames then `abort` → `frm_cnt`=10, no `done`, IDLE next cycle, `ospfb_en`=0.
- Fatal event: `event_tlast_missing` during frame 2 → ERROR, `err_flags`=4'b0100, `ospfb_en`=0 next cycle; `start` ignored; `abort` → IDLE with flags retained.
- Overflow: 3 `event_fft_overflow` pulses in RUN → without the macro, `ovf_cnt`=3, `err_flags[0]`=1, run completes; with `OSPFB_RUN_CTRL_OVF_HALT_EN`, ERROR after the first pulse with `ovf_cnt`=1.
- Collision: last tlast together with `event_tlast_unexpected` → `frm_cnt`=N, ERROR, no `done`; last tlast together with `abort` → IDLE, no `done`.
- Reset mid-CONFIG while `tready`=0 → next cycle all outputs are 0 and state is IDLE; a fresh `start` produces a correct run.
